lcd_text_ctrl: RTL
==================

# lcd_text_ctrl

Text-terminal controller between `uart_rx` and the character-LCD byte writer. Buffers received bytes in a small FIFO, runs the HD44780 power-up command sequence, then turns each byte into one or more LCD transactions. It tracks the cursor on a 16x2 display and handles line wrap, CR, LF, backspace and form feed. Only this block issues requests to the writer; the writer performs the bus timing.

## Interface
- `FIFO_DEPTH`, 16, byte-buffer entries (power of two, ≥2)
- `clk`  in  1  system clock (50 MHz)
- `reset`  in  1  asynchronous, active-high reset
- `rx_data`  in  8  received byte; sampled when `rx_valid`=1
- `rx_valid`  in  1  one-cycle strobe from `uart_rx`
- `lcd_req`  out  1  transaction request to the writer; held until `lcd_done`
- `lcd_rs`  out  1  0=command, 1=data; stable while `lcd_req`=1
- `lcd_byte`  out  8  command or data byte; stable while `lcd_req`=1
- `lcd_done`  in  1  one-cycle strobe from the writer: transaction complete
- `ready`  out  1  init sequence finished
- `overflow`  out  1  sticky: a byte was dropped because the FIFO was full

## Operation
- **Reset values:** `lcd_req`=0, `lcd_rs`=0, `lcd_byte`=0x00, `ready`=0, `overflow`=0, FIFO empty, row=0, col=0, state INIT.
- **INIT:** issues commands 0x38, 0x0C, 0x01, 0x06 in order, one transaction each. Goes to IDLE and sets `ready`=1 after the `lcd_done` for 0x06.
- **FIFO push:**
  - A push occurs on `rx_valid` in any state, including INIT.
  - Push when full with no pop in the same cycle: byte dropped, `overflow` set. Only `reset` clears `overflow`.
  - Push and pop in the same cycle: both take effect, including when the FIFO is full.
- **IDLE → DECODE:** in IDLE with the FIFO non-empty, pop into a byte register and go to DECODE.
- **DECODE:** builds a transaction list from the byte and current cursor. Set-address command = 0x80 | (row ? 0x40 : 0x00) + col.
  - 0x20–0x7E: write data byte, then col+1. If col was 15: col=0, row toggles, then a set-address command.
  - 0x0D (CR): col=0; set-address.
  - 0x0A (LF): row toggles, col=0; set-address.
  - 0x08 (BS): if col>0, col-1; set-address, data 0x20, set-address. If col=0, no transaction.
  - 0x0C (FF): command 0x01, then row=0, col=0.
  - All other codes: dropped, no transaction.
- **ISSUE / WAIT:** ISSUE drives `lcd_req` and the byte; WAIT holds until `lcd_done`. The next list entry follows, or the FSM returns to IDLE when the list is done.
- **Cursor:** row/col update at the `lcd_done` of the transaction that implies the change. Row 1 wraps to row 0; the display is not cleared.
- `lcd_done` while `lcd_req`=0 is ignored.

## Timing
- **Request latency:** FIFO empty and state IDLE, push at edge E0. Pop at E1, DECODE at E2; `lcd_req`=1 from E2.
- **Back-to-back:** `lcd_req` drops on the edge that samples `lcd_done`. The next request rises at the earliest one cycle later, so there is at least one low cycle between transactions.
- **Stability:** `lcd_rs` and `lcd_byte` change only while `lcd_req`=0.
- **Reset mid-transaction:** all state and outputs return to reset values immediately. INIT reruns from 0x38, and a pending `lcd_done` is ignored.
- **Throughput:** bounded by the writer. The FIFO absorbs bursts at 115200 baud against slow commands such as 0x01.

## Structure
- **Package `lcd_pkg`:**
  - command constants (FUNC_SET 0x38, DISP_ON 0x0C, CLEAR 0x01, ENTRY 0x06, SET_DDRAM 0x80, ROW1_BASE 0x40)
  - control-code constants (CR, LF, BS, FF)
  - COLS=16
  - FSM state enum (INIT, IDLE, DECODE, ISSUE, WAIT)
- **Sub-module `byte_fifo`:** synchronous FIFO with `FIFO_DEPTH` parameter, push/pop/full/empty, and an async active-high reset on the same `clk`/`reset`.

## Test plan
- **Reset, then `lcd_done` answered 3 cycles after each req** → bytes 0x38, 0x0C, 0x01, 0x06 with rs=0, then `ready`=1. Stimulus arriving during INIT is buffered, not lost.
- **"A" (0x41) after ready** → set-address not sent; data 0x41 with rs=1; `lcd_req` rises 2 cycles after the push; col=1.
- **17 × 0x42 from col 0** → 16 data writes, then cmd 0xC0 after the 16th, then the 17th data write; cursor row=1, col=1.
- **CR, LF, BS at row 1 col 3** → CR: 0xC0. LF: 0x80. BS at row 0 col 5: 0x84, data 0x20, 0x84.
- **Writer stalled, 20 bytes pushed (`FIFO_DEPTH`=16)** → `overflow`=1 after the 17th push into the full FIFO. The bytes held in the FIFO are later emitted in order.
- **`reset` asserted while `lcd_req`=1** → outputs at reset values the same cycle; INIT restarts with 0x38.

Source files
------------

// File: rtl/lcd_text_ctrl_pkg.sv
//------------------------------------------------------------------------------
// lcd_pkg : HD44780 command/control-code constants, FSM states, transaction type
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package lcd_pkg;

    localparam logic [7:0] FUNC_SET  = 8'h38;
    localparam logic [7:0] DISP_ON   = 8'h0C;
    localparam logic [7:0] CLEAR     = 8'h01;
    localparam logic [7:0] ENTRY     = 8'h06;
    localparam logic [7:0] SET_DDRAM = 8'h80;
    localparam logic [7:0] ROW1_BASE = 8'h40;

    localparam logic [7:0] CR        = 8'h0D;
    localparam logic [7:0] LF        = 8'h0A;
    localparam logic [7:0] BS        = 8'h08;
    localparam logic [7:0] FF        = 8'h0C;
    localparam logic [7:0] SPACE     = 8'h20;
    localparam logic [7:0] PRINT_LO  = 8'h20;
    localparam logic [7:0] PRINT_HI  = 8'h7E;

    localparam int COLS     = 16;
    localparam int COL_W    = $clog2(COLS);
    localparam int LIST_LEN = 4;

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        IDLE   = 3'd1,
        DECODE = 3'd2,
        ISSUE  = 3'd3,
        WAIT   = 3'd4
    } state_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } xact_t;

    function automatic xact_t set_addr(input logic row, input logic [COL_W-1:0] col);
        xact_t x;
        x.rs   = 1'b0;
        x.data = SET_DDRAM | (row ? ROW1_BASE : 8'h00) | {{(8-COL_W){1'b0}}, col};
        return x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_text_ctrl_if.sv
//------------------------------------------------------------------------------
// lcd_text_ctrl_if : byte input from uart_rx, request/done bus to the LCD writer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface lcd_text_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       lcd_req;
    logic       lcd_rs;
    logic [7:0] lcd_byte;
    logic       lcd_done;
    logic       ready;
    logic       overflow;

    modport master (
        input  rx_data, rx_valid, lcd_done,
        output lcd_req, lcd_rs, lcd_byte, ready, overflow
    );

    modport slave (
        output rx_data, rx_valid, lcd_done,
        input  lcd_req, lcd_rs, lcd_byte, ready, overflow
    );
endinterface

`default_nettype wire

// File: rtl/lcd_text_ctrl_byte_fifo.sv
//------------------------------------------------------------------------------
// byte_fifo : synchronous FIFO, first-word fall-through read, push+pop when full OK
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module byte_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (r_count == '0);
    assign w_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push  = push && (!full || w_pop);
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

`default_nettype wire

// File: rtl/lcd_text_ctrl.sv
//------------------------------------------------------------------------------
// lcd_text_ctrl : buffers UART bytes, runs HD44780 init, maps bytes to LCD transactions
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lcd_text_ctrl
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    lcd_text_ctrl_if.master       bus
);

    state_t           r_state;
    state_t           w_state_next;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [7:0]       w_fifo_data;
    logic             w_pop;

    logic [7:0]       r_byte;
    xact_t            r_list [LIST_LEN];
    logic [2:0]       r_len;
    logic [1:0]       r_idx;
    logic             r_upd;
    logic             r_new_row;
    logic [COL_W-1:0] r_new_col;
    logic             r_row;
    logic [COL_W-1:0] r_col;

    logic             r_req;
    logic             r_rs;
    logic [7:0]       r_data;
    logic             r_ready;
    logic             r_overflow;

    xact_t            w_dec [LIST_LEN];
    logic [2:0]       w_dec_len;
    logic             w_dec_upd;
    logic             w_dec_row;
    logic [COL_W-1:0] w_dec_col;
    logic [COL_W-1:0] w_bs_col;

    logic             w_start;
    logic             w_finish;
    logic             w_load;
    logic             w_set_ready;
    logic             w_last;
    xact_t            w_src;

    byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (bus.rx_valid),
        .pop     (w_pop),
        .wr_data (bus.rx_data),
        .rd_data (w_fifo_data),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    assign bus.lcd_req  = r_req;
    assign bus.lcd_rs   = r_rs;
    assign bus.lcd_byte = r_data;
    assign bus.ready    = r_ready;
    assign bus.overflow = r_overflow;

    assign w_last   = (({1'b0, r_idx} + 3'd1) == r_len);
    assign w_bs_col = r_col - 1'b1;

    // Transaction list for the byte in r_byte at the current cursor.
    always_comb begin
        for (int i = 0; i < LIST_LEN; i++) w_dec[i] = '0;
        w_dec_len = 3'd0;
        w_dec_upd = 1'b0;
        w_dec_row = r_row;
        w_dec_col = r_col;
        if (r_byte >= PRINT_LO && r_byte <= PRINT_HI) begin
            w_dec[0]  = {1'b1, r_byte};
            w_dec_upd = 1'b1;
            if (r_col == COL_W'(COLS - 1)) begin
                w_dec_row = ~r_row;
                w_dec_col = '0;
                w_dec[1]  = set_addr(~r_row, '0);
                w_dec_len = 3'd2;
            end else begin
                w_dec_col = r_col + 1'b1;
                w_dec_len = 3'd1;
            end
        end else begin
            case (r_byte)
                CR: begin
                    w_dec[0]  = set_addr(r_row, '0);
                    w_dec_col = '0;
                    w_dec_upd = 1'b1;
                    w_dec_len = 3'd1;
                end
                LF: begin
                    w_dec[0]  = set_addr(~r_row, '0);
                    w_dec_row = ~r_row;
                    w_dec_col = '0;
                    w_dec_upd = 1'b1;
                    w_dec_len = 3'd1;
                end
                BS: begin
                    if (r_col != '0) begin
                        w_dec[0]  = set_addr(r_row, w_bs_col);
                        w_dec[1]  = {1'b1, SPACE};
                        w_dec[2]  = set_addr(r_row, w_bs_col);
                        w_dec_col = w_bs_col;
                        w_dec_upd = 1'b1;
                        w_dec_len = 3'd3;
                    end
                end
                FF: begin
                    w_dec[0]  = {1'b0, CLEAR};
                    w_dec_row = 1'b0;
                    w_dec_col = '0;
                    w_dec_upd = 1'b1;
                    w_dec_len = 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= INIT;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_start      = 1'b0;
        w_finish     = 1'b0;
        w_load       = 1'b0;
        w_set_ready  = 1'b0;
        w_src        = r_list[r_idx];
        case (r_state)
            INIT: begin
                w_start      = 1'b1;
                w_state_next = WAIT;
            end
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = DECODE;
                end
            end
            DECODE: begin
                w_load = 1'b1;
                if (w_dec_len == 3'd0) begin
                    w_state_next = IDLE;
                end else begin
                    // First entry goes straight out; the list registers load in parallel.
                    w_src        = w_dec[0];
                    w_start      = 1'b1;
                    w_state_next = WAIT;
                end
            end
            ISSUE: begin
                w_start      = 1'b1;
                w_state_next = WAIT;
            end
            WAIT: begin
                if (bus.lcd_done) begin
                    w_finish = 1'b1;
                    if (w_last) begin
                        w_set_ready  = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = ISSUE;
                    end
                end
            end
            default: w_state_next = INIT;
        endcase
    end

    // The list reset value is the power-up sequence, so INIT reuses ISSUE/WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_list[0]  <= {1'b0, FUNC_SET};
            r_list[1]  <= {1'b0, DISP_ON};
            r_list[2]  <= {1'b0, CLEAR};
            r_list[3]  <= {1'b0, ENTRY};
            r_len      <= 3'd4;
            r_idx      <= 2'd0;
            r_upd      <= 1'b0;
            r_new_row  <= 1'b0;
            r_new_col  <= '0;
            r_row      <= 1'b0;
            r_col      <= '0;
            r_byte     <= 8'h00;
            r_req      <= 1'b0;
            r_rs       <= 1'b0;
            r_data     <= 8'h00;
            r_ready    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_start) begin
                r_req  <= 1'b1;
                r_rs   <= w_src.rs;
                r_data <= w_src.data;
            end else if (w_finish) begin
                r_req  <= 1'b0;
            end
            if (w_finish) begin
                r_idx <= r_idx + 1'b1;
                if (r_idx == 2'd0 && r_upd) begin
                    r_row <= r_new_row;
                    r_col <= r_new_col;
                end
            end
            if (w_load) begin
                r_list    <= w_dec;
                r_len     <= w_dec_len;
                r_idx     <= 2'd0;
                r_upd     <= w_dec_upd;
                r_new_row <= w_dec_row;
                r_new_col <= w_dec_col;
            end
            if (w_set_ready) r_ready <= 1'b1;
            if (w_pop)       r_byte  <= w_fifo_data;
            if (bus.rx_valid && w_fifo_full && !w_pop) r_overflow <= 1'b1;
        end
    end

endmodule

`default_nettype wire
